// File: rtl/alu4_seq.sv
// alu4_seq -- multi-nibble sequencer in front of a combinational 4-bit ALU.
//
// Takes one W-bit command (W = 4*NIBBLES) over cmd_valid/cmd_ready, drives the
// external ALU one nibble per cycle (LSB nibble first), chains the carry
// between passes, and returns the assembled result and flags over
// rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op[2:0]                   000 add, 001 sub, 010 not, 011 and,
//                                 100 or, 101 xor, 110 compare, 111 equal
//   cmd_a, cmd_b [W-1:0]          operands (cmd_b ignored for not)
//   cmd_cin                       carry-in, used by add on the first pass only
//   rsp_valid/rsp_ready           response handshake
//   rsp_result[W-1:0]             assembled result
//   rsp_zero/overflow/carry/size  response flags
//   busy                          sequencer not idle
//   alu_a/alu_b/alu_c/alu_cin     registered drives to the ALU
//   alu_result/zero/overflow/carry/size  ALU outputs (alu_zero unused)
//
// Optional: define ALU4_SEQ_STATS_EN to add saturating 16-bit counters
// stat_ops (response handshakes) and stat_ovf (handshakes with overflow).
module alu4_seq #(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_overflow,
  output logic         rsp_carry,
  output logic         rsp_size,
  output logic         busy,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_c,
  output logic         alu_cin,
  input  logic [3:0]   alu_result,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         alu_carry,
  input  logic         alu_size
`ifdef ALU4_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NOT = 3'b010, OP_AND = 3'b011,
    OP_OR  = 3'b100, OP_XOR = 3'b101, OP_CMP = 3'b110, OP_EQ  = 3'b111
  } op_e;

  state_e         state_q;
  op_e            op_q;
  logic [W-1:0]   a_sh_q, b_sh_q;   // remaining operand nibbles, shifted down
  logic [W-1:0]   res_q;            // result nibbles collected so far
  logic [2:0]     idx_q;
  logic [3:0]     alu_a_q, alu_b_q;
  logic           alu_cin_q;
  logic           rsp_valid_q, rsp_zero_q, rsp_overflow_q, rsp_carry_q, rsp_size_q;
  logic [W-1:0]   rsp_result_q;

  logic           first_cin_d;
  logic           arith;
  logic           last_pass;
  logic [W+3:0]   res_cat;
  logic [W-1:0]   res_d;
  logic           unused_alu_zero;

  // The zero flag is recomputed over the whole W-bit result.
  assign unused_alu_zero = alu_zero;

  // Logic ops (not/and/or/xor) never chain carry and never report flags.
  assign arith     = !(op_q inside {OP_NOT, OP_AND, OP_OR, OP_XOR});
  assign last_pass = (idx_q == 3'(NIBBLES - 1));

  // Current ALU nibble enters at the top while earlier nibbles shift down,
  // so after NIBBLES passes nibble 0 sits at the bottom.
  assign res_cat = {alu_result, res_q};
  assign res_d   = res_cat[W+3:4];

  always_comb begin
    first_cin_d = 1'b0;
    case (op_e'(cmd_op))
      OP_ADD:               first_cin_d = cmd_cin;
      OP_SUB, OP_CMP, OP_EQ: first_cin_d = 1'b1;  // a + ~b + 1
      default:              first_cin_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= OP_ADD;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      res_q          <= '0;
      idx_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_cin_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_size_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            // Pass-0 drives are registered at accept so the ALU sees them
            // for the whole first EXEC cycle.
            op_q      <= op_e'(cmd_op);
            alu_a_q   <= cmd_a[3:0];
            alu_b_q   <= cmd_b[3:0];
            alu_cin_q <= first_cin_d;
            a_sh_q    <= cmd_a >> 4;
            b_sh_q    <= cmd_b >> 4;
            idx_q     <= '0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          res_q <= res_d;
          if (last_pass) begin
            rsp_result_q   <= res_d;
            rsp_zero_q     <= (res_d == '0);
            rsp_overflow_q <= arith && alu_overflow;
            rsp_carry_q    <= arith && alu_carry;
            rsp_size_q     <= (op_q == OP_CMP) ? alu_size :
                              (op_q == OP_EQ)  ? (res_d == '0) : 1'b0;
            rsp_valid_q    <= 1'b1;
            state_q        <= RESP;
          end else begin
            alu_a_q   <= a_sh_q[3:0];
            alu_b_q   <= b_sh_q[3:0];
            alu_cin_q <= arith && alu_carry;
            a_sh_q    <= a_sh_q >> 4;
            b_sh_q    <= b_sh_q >> 4;
            idx_q     <= idx_q + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU4_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_ovf_q;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (rsp_overflow_q && stat_ovf_q != 16'hFFFF) stat_ovf_q <= stat_ovf_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_size     = rsp_size_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_c        = op_q;
  assign alu_cin      = alu_cin_q;

endmodule

// File: tb/tb_alu4_seq.sv
// Testbench for alu4_seq (NIBBLES=2). A behavioural 4-bit ALU model closes
// the loop; for logic ops it drives all flags high so the sequencer's
// flag masking is visible.
module tb_alu4_seq;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic         cmd_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_overflow, rsp_carry, rsp_size;
  logic         busy;
  logic [3:0]   alu_a, alu_b;
  logic [2:0]   alu_c;
  logic         alu_cin;
  logic [3:0]   alu_result;
  logic         alu_zero, alu_overflow, alu_carry, alu_size;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu4_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .rsp_size(rsp_size), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_size(alu_size)
  );

  // 4-bit ALU model: arith ops compute a + (b or ~b) + cin; size = signed a<b.
  logic [3:0] m_bb;
  logic [4:0] m_sum;
  always_comb begin
    m_bb         = alu_b;
    m_sum        = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_size     = 1'b0;
    case (alu_c)
      3'b000, 3'b001, 3'b110, 3'b111: begin
        if (alu_c != 3'b000) m_bb = ~alu_b;
        m_sum        = {1'b0, alu_a} + {1'b0, m_bb} + {4'b0, alu_cin};
        alu_result   = m_sum[3:0];
        alu_carry    = m_sum[4];
        alu_overflow = (alu_a[3] == m_bb[3]) && (m_sum[3] != alu_a[3]);
        alu_size     = m_sum[3] ^ alu_overflow;
      end
      default: begin
        case (alu_c)
          3'b010:  alu_result = ~alu_a;
          3'b011:  alu_result = alu_a & alu_b;
          3'b100:  alu_result = alu_a | alu_b;
          default: alu_result = alu_a ^ alu_b;
        endcase
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        alu_size     = 1'b1;
      end
    endcase
    alu_zero = (alu_result == 4'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command (called at a negedge while idle) and check its response.
  // hold = cycles rsp_ready stays low after rsp_valid rises.
  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] e_res, input logic e_zero, input logic e_ovf,
                       input logic e_carry, input logic e_size,
                       input logic e_cin0, input logic e_cin1, input int hold);
    int waits;
    int lat;
    logic [1:0] cins;
    logic [W+3:0] snap;
    waits = 0;
    lat = 0;
    cins = '0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({name, " accept_wait"}, waits, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= NIB) cins[lat-1] = alu_cin;
    end while (!rsp_valid && lat < 20);
    check({name, " latency"}, lat, NIB + 1);
    check({name, " cin_pass0"}, cins[0], e_cin0);
    check({name, " cin_pass1"}, cins[1], e_cin1);
    check({name, " result"}, rsp_result, e_res);
    check({name, " flags z/o/c/s"}, {rsp_zero, rsp_overflow, rsp_carry, rsp_size},
          {e_zero, e_ovf, e_carry, e_size});
    if (hold > 0) begin
      snap = {rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_size};
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({name, " bp_stable"}, {rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_size}, snap);
        check({name, " bp_valid/ready/busy"}, {rsp_valid, cmd_ready, busy}, 3'b101);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check({name, " post_hs valid/ready/busy"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("reset valid/ready/busy", {rsp_valid, cmd_ready, busy}, 3'b010);
    check("reset alu drives", {alu_a, alu_b, alu_c, alu_cin}, 12'h000);
    check("reset rsp", {rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_size}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    //     name    op      a      b      cin   result zero ovf  carry size cin0 cin1 hold
    do_op("add7F", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    do_op("sub",   3'b001, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    do_op("cmpOv", 3'b110, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    do_op("cmpEq", 3'b110, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    do_op("eqT",   3'b111, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    do_op("eqF",   3'b111, 8'h5A, 8'h5B, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_op("and",   3'b011, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op("xor",   3'b101, 8'hA5, 8'hFF, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op("not",   3'b010, 8'h3C, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op("or",    3'b100, 8'h12, 8'h48, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Wrap: carry-out reported, never folded into the result.
    do_op("addWr", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    do_op("addCi", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    // Backpressure, then a command accepted in the very next idle cycle.
    do_op("bp",    3'b000, 8'h22, 8'h33, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    do_op("afterBp", 3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Asynchronous reset during EXEC pass 0 drops the operation.
    cmd_op = 3'b000; cmd_a = 8'h33; cmd_b = 8'h44; cmd_cin = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("pass0 alu drives", {alu_a, alu_b, alu_c, alu_cin}, {4'h3, 4'h4, 3'b000, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("midrst alu drives", {alu_a, alu_b, alu_c, alu_cin}, 12'h000);
    check("midrst valid/ready/busy", {rsp_valid, cmd_ready, busy}, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (rsp_valid || busy) seen++;
      end
      check("midrst no response", seen, 0);
    end
    do_op("postRst", 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu4_seq.md
Name: alu4_seq

Overview:
- Multi-nibble operation sequencer that sits directly upstream of the combinational 4-bit ALU.
- Accepts one W-bit command (W = 4*NIBBLES) over a valid/ready handshake and drives the ALU one nibble per cycle, LSB nibble first.
- Chains carry between passes, collects the result nibbles and flags, and returns one response over a valid/ready handshake.
- Extends the 4-bit ALU to 8/12/16-bit operands without changing the ALU.

Parameters:
NIBBLES, 2, number of 4-bit passes; operand width W = 4*NIBBLES; legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  ALU function code: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 compare, 111 equal
cmd_a  input  W  operand a
cmd_b  input  W  operand b (ignored for 010)
cmd_cin  input  1  carry-in; used only by op 000 on the first pass
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  W  assembled result
rsp_zero  output  1  rsp_result == 0 (all ops)
rsp_overflow  output  1  final-pass alu_overflow (arith ops 000/001/110/111), else 0
rsp_carry  output  1  final-pass alu_carry (arith ops), else 0
rsp_size  output  1  op 110: final-pass alu_size; op 111: equals rsp_zero; else 0
busy  output  1  state != IDLE
alu_a  output  4  current nibble of a to ALU
alu_b  output  4  current nibble of b to ALU
alu_c  output  3  function select to ALU
alu_cin  output  1  carry-in to ALU
alu_result  input  4  ALU result
alu_zero  input  1  ALU zero flag (unused; zero is computed locally)
alu_overflow  input  1  ALU overflow
alu_carry  input  1  ALU carry
alu_size  input  1  ALU size flag

Behaviour:
- Reset (async, any state): state=IDLE.
  - All rsp_* = 0; rsp_valid = 0.
  - alu_a, alu_b, alu_c, alu_cin = 0.
  - Nibble index = 0.
  - An in-flight operation is dropped silently; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op/a/b/cin into registers, index=0, go to EXEC.
- EXEC, pass i (one cycle per pass):
  - Registered drives: alu_a=a[4i+3:4i], alu_b=b[4i+3:4i], alu_c=op.
  - alu_cin on pass 0: cmd_cin for op 000; 1 for ops 001/110/111; 0 for logic ops.
  - alu_cin on pass i>0: previous pass alu_carry for arith ops; 0 for logic ops.
  - ALU output is sampled at the end of the same cycle into result[4i+3:4i]; alu_carry is kept for chaining.
  - After pass NIBBLES-1: latch the final-pass overflow/carry/size, compute zero over the full W-bit result, go to RESP.
  - cmd_ready=0 throughout.
- RESP:
  - rsp_valid=1; all rsp_* stay stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid=0 next cycle, go to IDLE.
  - cmd_ready=0; a new command is accepted no earlier than the cycle after the handshake.
- Latency: command accepted in cycle 0; rsp_valid high from cycle NIBBLES+1.
- Throughput: one op per NIBBLES+2 cycles with rsp_ready held at 1.
- Outside EXEC, alu_* hold their last values; nothing is sampled from the ALU.
- Arithmetic is modulo 2^W; carry-out of the top nibble is reported and never wraps into the result.
- NIBBLES=1 degenerates to a registered single pass and uses the same rules.

Optional Feature:
- Macro ALU4_SEQ_STATS_EN.
- When defined:
  - Extra output ports stat_ops (16-bit) and stat_ovf (16-bit).
  - stat_ops increments on every response handshake.
  - stat_ovf increments on every response handshake where rsp_overflow=1.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. NIBBLES=2, op 000, a=0x7F, b=0x01, cin=0 -> rsp_result=0x80, overflow=1, carry=0, zero=0; rsp_valid exactly 3 cycles after accept; pass 1 alu_cin=1 (chained carry).
2. op 001, a=0x10, b=0x01 -> pass 0 alu_cin=1; rsp_result=0x0F, carry=1, overflow=0, zero=0.
3. op 110, a=0x80, b=0x01 -> rsp_result=0x7F, overflow=1, rsp_size=1; op 110, a=0x05, b=0x05 -> zero=1, overflow=0, rsp_size=0.
4. op 111, a=0x5A, b=0x5A -> zero=1, size=1; a=0x5A, b=0x5B -> zero=0, size=0; op 011, a=0xF0, b=0x0F -> result=0x00, zero=1, carry=0, overflow=0.
5. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_* stable, cmd_ready=0, busy=1; raise rsp_ready -> handshake, IDLE the next cycle, a following command is accepted one cycle later.
6. Assert rst during EXEC pass 0 -> all outputs 0 immediately (async), no response emitted; after release, op 000, a=0x01, b=0x01 -> result=0x02 with normal latency.
